// File: rtl/window_pkg.sv
// -----------------------------------------------------------------------------
// window_pkg
// Shared definitions for the KxK sliding-window generator.
//   state_t        : FILL / STREAM / DRAIN window-generator states
//   COL_CNT_W, PAD : column-counter width and "same" padding amount for the
//                    default geometry (FEATURE_MAP_WIDTH=1024, K=3)
//   pixel_t        : one pixel at the default IO_DATA_WIDTH
//   col_cnt_width(), pad_of() : the same quantities for any geometry, used by
//                    the parameterised modules
// -----------------------------------------------------------------------------
package window_pkg;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   localparam int DEF_IO_DATA_WIDTH     = 16;
   localparam int DEF_KERNEL_SIZE       = 3;
   localparam int DEF_FEATURE_MAP_WIDTH = 1024;

   localparam int COL_CNT_W = $clog2(DEF_FEATURE_MAP_WIDTH);
   localparam int PAD       = (DEF_KERNEL_SIZE - 1) / 2;

   typedef logic [DEF_IO_DATA_WIDTH-1:0] pixel_t;

   // Counter width able to hold 0..fmw-1 (at least one bit).
   function automatic int col_cnt_width(input int fmw);
      return (fmw > 1) ? $clog2(fmw) : 1;
   endfunction

   // "Same" padding for a KxK kernel.
   function automatic int pad_of(input int k);
      return (k - 1) / 2;
   endfunction

endpackage

// File: rtl/window_row_shifter.sv
// -----------------------------------------------------------------------------
// window_row_shifter
// One kernel row of the window: a K-deep pixel shift register.
//   clk, arst_in : clock, asynchronous active-high reset (clears all taps)
//   shift_en     : shift din into tap 0, tap c moves to tap c+1
//   clear        : synchronous clear of the row; combined with shift_en the
//                  row restarts holding only din in tap 0
//   din          : incoming pixel
//   taps         : registered taps, slice c = tap c (0 newest, K-1 oldest)
// -----------------------------------------------------------------------------
module window_row_shifter
   import window_pkg::*;
#(
   parameter int W = DEF_IO_DATA_WIDTH,
   parameter int K = DEF_KERNEL_SIZE
) (
   input  logic           clk,
   input  logic           arst_in,
   input  logic           shift_en,
   input  logic           clear,
   input  logic [W-1:0]   din,
   output logic [K*W-1:0] taps
);

   // Shift / clear of the pixel taps.
   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         taps <= {(K*W){1'b0}};
      end else if (shift_en) begin
         if (clear) begin
            taps <= {{((K-1)*W){1'b0}}, din};
         end else begin
            taps <= {taps[(K-1)*W-1:0], din};
         end
      end else if (clear) begin
         taps <= {(K*W){1'b0}};
      end else begin
         taps <= taps;
      end
   end

endmodule

// File: rtl/window_shift_array.sv
// -----------------------------------------------------------------------------
// window_shift_array
// KxK sliding-window generator. One K-pixel column is accepted per handshake
// and shifted into a KxK register array; the array itself is the output stage.
// Windows never straddle a feature-map row; horizontal stride 1 or 2.
// Optional macro WINDOW_ZERO_PAD_EN enables "same" zero padding (row-start
// clear, shortened fill, internal drain of PAD zero columns).
// Ports:
//   clk, arst_in  : clock, asynchronous active-high reset
//   in_valid/in_ready/in_col        : column input, slice r = kernel row r
//   out_valid/out_ready/out_window  : window output, slice (r*K+c),
//                                     c=0 newest column, c=K-1 oldest
//   out_row_last  : qualifies out_valid, last window of the row
// -----------------------------------------------------------------------------
module window_shift_array
   import window_pkg::*;
#(
   parameter int IO_DATA_WIDTH     = DEF_IO_DATA_WIDTH,
   parameter int KERNEL_SIZE       = DEF_KERNEL_SIZE,
   parameter int FEATURE_MAP_WIDTH = DEF_FEATURE_MAP_WIDTH,
   parameter int STRIDE            = 1
) (
   input  logic                                           clk,
   input  logic                                           arst_in,
   input  logic                                           in_valid,
   output logic                                           in_ready,
   input  logic [KERNEL_SIZE*IO_DATA_WIDTH-1:0]           in_col,
   output logic                                           out_valid,
   input  logic                                           out_ready,
   output logic [KERNEL_SIZE*KERNEL_SIZE*IO_DATA_WIDTH-1:0] out_window,
   output logic                                           out_row_last
);

   localparam int W      = IO_DATA_WIDTH;
   localparam int K      = KERNEL_SIZE;
   localparam int CNT_W  = col_cnt_width(FEATURE_MAP_WIDTH);
   localparam int PAD_N  = pad_of(KERNEL_SIZE);
`ifdef WINDOW_ZERO_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif
   // Columns needed before the first window, and zero columns appended at
   // the end of a row.
   localparam int FILL_LEN  = PAD_EN ? (PAD_N + 1) : K;
   localparam int DRAIN_LEN = PAD_EN ? PAD_N : 0;
   // Candidate windows per row (before stride decimation).
   localparam int NUM_CAND  = FEATURE_MAP_WIDTH - FILL_LEN + 1 + DRAIN_LEN;
   localparam int CAND_W    = CNT_W + 1;

   localparam logic [CNT_W-1:0]  COL_LAST    = CNT_W'(FEATURE_MAP_WIDTH - 1);
   localparam logic [CNT_W-1:0]  FILL_LAST   = CNT_W'(FILL_LEN - 1);
   localparam logic [CAND_W-1:0] CAND_LAST   = CAND_W'(NUM_CAND - 1);
   localparam logic [CAND_W-1:0] CAND_PENULT = CAND_W'(NUM_CAND - 2);
   localparam logic [2:0]        DRAIN_LAST  = 3'(DRAIN_LEN - 1);
   localparam state_t            ROW_DONE    = (PAD_EN && (PAD_N > 0)) ? DRAIN : FILL;

   state_t              state_r;
   logic [CNT_W-1:0]    col_cnt_r;
   logic                stride_cnt_r;
   logic [CAND_W-1:0]   cand_cnt_r;
   logic [2:0]          drain_cnt_r;

   logic                out_free_s;
   logic                acc_s;
   logic                drain_step_s;
   logic                shift_en_s;
   logic                row_clear_s;
   logic [K*W-1:0]      shift_col_s;
   logic                phase_s;
   logic                fill_end_s;
   logic                step_s;
   logic [CAND_W-1:0]   cand_idx_s;
   logic                emit_s;
   logic                last_s;
   logic                row_end_s;

   // Handshake, shift control and window-emission decode.
   always_comb begin
      out_free_s   = !out_valid || out_ready;
      in_ready     = out_free_s && (state_r != DRAIN);
      acc_s        = in_valid && in_ready;
      drain_step_s = PAD_EN && (state_r == DRAIN) && out_free_s;
      shift_en_s   = acc_s || drain_step_s;
      // Padding mode starts each row from an all-zero window.
      row_clear_s  = PAD_EN && acc_s && (col_cnt_r == {CNT_W{1'b0}});
      shift_col_s  = drain_step_s ? {(K*W){1'b0}} : in_col;
      // stride_cnt holds the phase of the previous candidate; phase 0 emits.
      phase_s      = (STRIDE == 2) ? ~stride_cnt_r : 1'b0;
      fill_end_s   = 1'b0;
      step_s       = 1'b0;
      case (state_r)
         FILL:    fill_end_s = acc_s && (col_cnt_r == FILL_LAST);
         STREAM:  step_s     = acc_s;
         DRAIN:   step_s     = drain_step_s;
         default: step_s     = 1'b0;
      endcase
      cand_idx_s = fill_end_s ? {CAND_W{1'b0}} : (cand_cnt_r + CAND_W'(1));
      emit_s     = fill_end_s || (step_s && (phase_s == 1'b0));
      // With stride 2 the final candidate of a row may be skipped, so the
      // window just before it already carries the row-last flag.
      last_s     = (cand_idx_s == CAND_LAST) ||
                   ((STRIDE == 2) && (cand_idx_s == CAND_PENULT));
      row_end_s  = acc_s && (col_cnt_r == COL_LAST);
   end

   // Window-generator FSM, counters and registered output qualifiers.
   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         state_r      <= FILL;
         col_cnt_r    <= {CNT_W{1'b0}};
         stride_cnt_r <= 1'b0;
         cand_cnt_r   <= {CAND_W{1'b0}};
         drain_cnt_r  <= 3'd0;
         out_valid    <= 1'b0;
         out_row_last <= 1'b0;
      end else begin
         if (emit_s) begin
            out_valid    <= 1'b1;
            out_row_last <= last_s;
         end else if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
            out_row_last <= 1'b0;
         end else begin
            out_valid    <= out_valid;
            out_row_last <= out_row_last;
         end

         if (acc_s) begin
            col_cnt_r <= row_end_s ? {CNT_W{1'b0}} : (col_cnt_r + CNT_W'(1));
         end else begin
            col_cnt_r <= col_cnt_r;
         end

         if (fill_end_s) begin
            stride_cnt_r <= 1'b0;
            cand_cnt_r   <= {CAND_W{1'b0}};
         end else if (step_s) begin
            stride_cnt_r <= phase_s;
            cand_cnt_r   <= cand_idx_s;
         end else begin
            stride_cnt_r <= stride_cnt_r;
            cand_cnt_r   <= cand_cnt_r;
         end

         case (state_r)
            FILL: begin
               drain_cnt_r <= 3'd0;
               if (fill_end_s) begin
                  state_r <= row_end_s ? ROW_DONE : STREAM;
               end else begin
                  state_r <= FILL;
               end
            end
            STREAM: begin
               drain_cnt_r <= 3'd0;
               if (row_end_s) begin
                  state_r <= ROW_DONE;
               end else begin
                  state_r <= STREAM;
               end
            end
            DRAIN: begin
               if (drain_step_s) begin
                  if (drain_cnt_r == DRAIN_LAST) begin
                     state_r     <= FILL;
                     drain_cnt_r <= 3'd0;
                  end else begin
                     state_r     <= DRAIN;
                     drain_cnt_r <= drain_cnt_r + 3'd1;
                  end
               end else begin
                  state_r     <= DRAIN;
                  drain_cnt_r <= drain_cnt_r;
               end
            end
            default: begin
               state_r     <= FILL;
               drain_cnt_r <= 3'd0;
            end
         endcase
      end
   end

   // One shifter per kernel row; its taps are that row's slice of the window.
   for (genvar r = 0; r < K; r++) begin : g_row
      window_row_shifter #(
         .W (W),
         .K (K)
      ) u_row (
         .clk      (clk),
         .arst_in  (arst_in),
         .shift_en (shift_en_s),
         .clear    (row_clear_s),
         .din      (shift_col_s[r*W +: W]),
         .taps     (out_window[r*K*W +: K*W])
      );
   end

endmodule

// File: tb/tb_window_shift_array.sv
// Bench for window_shift_array: two instances (stride 1 and stride 2) fed the
// same column stream, checked every cycle against windows computed directly
// from the row contents.
module tb_window_shift_array;
   import window_pkg::*;

   localparam int W    = 16;
   localparam int K    = 3;
   localparam int FMW  = 8;
   localparam int CW   = K * W;
   localparam int WW   = K * K * W;
   localparam int MAXC = 64;
   localparam int MAXW = 64;
`ifdef WINDOW_ZERO_PAD_EN
   localparam int LP = K - 1 - PAD;
   localparam int RP = PAD;
`else
   localparam int LP = 0;
   localparam int RP = 0;
`endif

   logic          clk = 1'b0;
   logic          arst_in;
   logic          in_valid [2];
   logic          in_ready [2];
   logic [CW-1:0] in_col [2];
   logic          out_valid [2];
   logic          out_ready [2];
   logic [WW-1:0] out_window [2];
   logic          out_row_last [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      window_shift_array #(
         .IO_DATA_WIDTH     (W),
         .KERNEL_SIZE       (K),
         .FEATURE_MAP_WIDTH (FMW),
         .STRIDE            (g + 1)
      ) u_dut (
         .clk          (clk),
         .arst_in      (arst_in),
         .in_valid     (in_valid[g]),
         .in_ready     (in_ready[g]),
         .in_col       (in_col[g]),
         .out_valid    (out_valid[g]),
         .out_ready    (out_ready[g]),
         .out_window   (out_window[g]),
         .out_row_last (out_row_last[g])
      );
   end

   int            checks = 0;
   int            errors = 0;
   logic [CW-1:0] cols [0:MAXC-1];
   int            ncols;
   logic [WW-1:0] exp_win [2][0:MAXW-1];
   logic          exp_last [2][0:MAXW-1];
   int            exp_n [2];
   int            rd [2];
   int            cp [2];

   task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic pixel_t slice(input logic [WW-1:0] w, input int r, input int c);
      return w[(r*K+c)*W +: W];
   endfunction

   // Reference: pad each row, slide a K-wide window with the given stride.
   task automatic build_model(input int nrows);
      logic [WW-1:0] w;
      int            last_idx;
      int            len;
      int            p;
      for (int g = 0; g < 2; g++) begin
         exp_n[g] = 0;
         for (int row = 0; row < nrows; row++) begin
            len      = LP + FMW + RP;
            last_idx = 0;
            for (int s = 0; s + K <= len; s += (g + 1)) begin
               w = {WW{1'b0}};
               for (int r = 0; r < K; r++) begin
                  for (int c = 0; c < K; c++) begin
                     p = s + K - 1 - c - LP;
                     if (p >= 0 && p < FMW) w[(r*K+c)*W +: W] = cols[row*FMW + p][r*W +: W];
                  end
               end
               exp_win[g][exp_n[g]]  = w;
               exp_last[g][exp_n[g]] = 1'b0;
               last_idx = exp_n[g];
               exp_n[g]++;
            end
            exp_last[g][last_idx] = 1'b1;
         end
      end
   endtask

   task automatic prepare_stream(input int nrows, input bit det);
      pixel_t px;
      ncols = nrows * FMW;
      for (int i = 0; i < ncols; i++) begin
         for (int r = 0; r < K; r++) begin
            px = det ? pixel_t'((i / FMW) * 256 + r * 16 + (i % FMW)) : pixel_t'($urandom);
            cols[i][r*W +: W] = px;
         end
      end
      build_model(nrows);
      for (int g = 0; g < 2; g++) begin
         rd[g] = 0;
         cp[g] = 0;
      end
   endtask

   task automatic sample(input int g);
`ifdef WINDOW_ZERO_PAD_EN
      if (out_valid[g] && !out_ready[g]) check($sformatf("in_ready_stall g%0d", g), in_ready[g], 1'b0);
`else
      check($sformatf("in_ready g%0d", g), in_ready[g], !out_valid[g] || out_ready[g]);
`endif
      if (out_valid[g]) begin
         if (rd[g] < exp_n[g]) begin
            check($sformatf("window g%0d #%0d", g, rd[g]), out_window[g], exp_win[g][rd[g]]);
            check($sformatf("row_last g%0d #%0d", g, rd[g]), out_row_last[g], exp_last[g][rd[g]]);
            if (out_ready[g]) rd[g]++;
         end else begin
            checks++;
            errors++;
            $display("FAIL extra_window g%0d: got window %0d expected only %0d", g, rd[g] + 1, exp_n[g]);
         end
      end
      if (in_valid[g] && in_ready[g]) cp[g]++;
   endtask

   task automatic drive_stream(input bit stall);
      bit done;
      done = 1'b0;
      for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
         @(posedge clk);
         #1;
         for (int g = 0; g < 2; g++) begin
            in_valid[g]  = (cp[g] < ncols) && (!stall || ($urandom_range(3) != 0));
            in_col[g]    = (cp[g] < ncols) ? cols[cp[g]] : {CW{1'b0}};
            out_ready[g] = !stall || ($urandom_range(1) == 1);
         end
         @(negedge clk);
         for (int g = 0; g < 2; g++) sample(g);
         done = 1'b1;
         for (int g = 0; g < 2; g++) begin
            if (cp[g] != ncols || rd[g] != exp_n[g] || out_valid[g]) done = 1'b0;
         end
      end
      check("stream_done", done, 1'b1);
      for (int g = 0; g < 2; g++) begin
         check($sformatf("win_count g%0d", g), rd[g], exp_n[g]);
         in_valid[g] = 1'b0;
      end
   endtask

   initial begin
      arst_in = 1'b1;
      for (int g = 0; g < 2; g++) begin
         in_valid[g]  = 1'b0;
         in_col[g]    = {CW{1'b0}};
         out_ready[g] = 1'b1;
      end
      #12;
      for (int g = 0; g < 2; g++) begin
         check($sformatf("rst out_valid g%0d", g), out_valid[g], 1'b0);
         check($sformatf("rst row_last g%0d", g), out_row_last[g], 1'b0);
         check($sformatf("rst window g%0d", g), out_window[g], {WW{1'b0}});
      end
      @(negedge clk);
      arst_in = 1'b0;
      #1;
      for (int g = 0; g < 2; g++) check($sformatf("rst in_ready g%0d", g), in_ready[g], 1'b1);

      // Two deterministic rows, pixel = row*256 + r*16 + col.
      prepare_stream(2, 1'b1);
`ifdef WINDOW_ZERO_PAD_EN
      check("pin pad count s1", exp_n[0], 16);
      check("pin pad count s2", exp_n[1], 8);
      check("pin pad first c2", slice(exp_win[0][0], 1, 2), 16'h0000);
      check("pin pad first c0", slice(exp_win[0][0], 1, 0), 16'h0011);
      check("pin pad last c0", slice(exp_win[0][7], 2, 0), 16'h0000);
      check("pin pad last c1", slice(exp_win[0][7], 2, 1), 16'h0027);
      check("pin pad last flag", exp_last[0][7], 1'b1);
`else
      check("pin count s1", exp_n[0], 12);
      check("pin count s2", exp_n[1], 6);
      check("pin first r1c0", slice(exp_win[0][0], 1, 0), 16'h0012);
      check("pin first r1c2", slice(exp_win[0][0], 1, 2), 16'h0010);
      check("pin last flag w5", exp_last[0][5], 1'b1);
      check("pin last flag w4", exp_last[0][4], 1'b0);
      check("pin row1 oldest", slice(exp_win[0][6], 0, 2), 16'h0100);
      check("pin s2 oldest 0", slice(exp_win[1][0], 0, 2), 16'h0000);
      check("pin s2 oldest 1", slice(exp_win[1][1], 0, 2), 16'h0002);
      check("pin s2 oldest 2", slice(exp_win[1][2], 0, 2), 16'h0004);
      check("pin s2 last flag", exp_last[1][2], 1'b1);
`endif
      drive_stream(1'b0);

      // Random data with random input gaps and output stalls.
      prepare_stream(3, 1'b0);
      drive_stream(1'b1);

      // Reset in the middle of a row, after 4 columns.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         for (int g = 0; g < 2; g++) begin
            in_valid[g]  = 1'b1;
            in_col[g]    = CW'({$urandom, $urandom});
            out_ready[g] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) in_valid[g] = 1'b0;
      check("pre-reset out_valid g0", out_valid[0], 1'b1);
      #1;
      arst_in = 1'b1;
      #1;
      for (int g = 0; g < 2; g++) begin
         check($sformatf("mid-reset out_valid g%0d", g), out_valid[g], 1'b0);
         check($sformatf("mid-reset window g%0d", g), out_window[g], {WW{1'b0}});
      end
      @(negedge clk);
      arst_in = 1'b0;
      prepare_stream(2, 1'b0);
      drive_stream(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
